fp_align: RTL and testbench

FP_ALIGN -- requirements
Module: fp_align

---
 rtl/fp_pkg.sv | 20 ++
 rtl/fp_unpack.sv | 33 +++
 rtl/fp_align.sv | 157 +++++++++++++++
 tb/tb_fp_align.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and sizing for the floating-point operand aligner.
package fp_pkg;

    localparam int MANT_W    = 24;
    localparam int EXP_W     = 8;
    localparam int MAX_SHIFT = 26;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [22:0]      frac;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } align_state_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational operand split: effective exponent, implicit bit, swap decision
// and the saturated exponent difference.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0]       aIn,
    input  logic [31:0]       bIn,
    output logic [MANT_W-1:0] mantA,
    output logic [MANT_W-1:0] mantB,
    output logic [EXP_W-1:0]  expA,
    output logic [EXP_W-1:0]  expB,
    output logic              swap,
    output logic [4:0]        diffSat
);

    fp32_t            opA;
    fp32_t            opB;
    logic [EXP_W-1:0] expDiff;

    assign opA = aIn;
    assign opB = bIn;

    // Subnormals: no implicit one, and they sit at exponent 1, not 0.
    assign expA  = (opA.exp == '0) ? EXP_W'(1) : opA.exp;
    assign expB  = (opB.exp == '0) ? EXP_W'(1) : opB.exp;
    assign mantA = {opA.exp != '0, opA.frac};
    assign mantB = {opB.exp != '0, opB.frac};

    assign swap    = (expB > expA) || ((expB == expA) && (mantB > mantA));
    assign expDiff = swap ? (expB - expA) : (expA - expB);
    assign diffSat = (expDiff > EXP_W'(MAX_SHIFT)) ? 5'(MAX_SHIFT) : expDiff[4:0];

endmodule

// File: rtl/fp_align.sv
// Multi-cycle FP32 operand aligner: shifts the smaller mantissa right by STEP
// bits per cycle collecting guard/round/sticky. Define FP_ALIGN_SPECIAL_EN to
// bypass alignment for exponent-255 operands and expose the special output.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// SHIFT | aligning small mantissa, remaining counts down to zero
// DONE  | result held, out_valid high until out_ready
module fp_align
    import fp_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] large_mant,
    output logic [23:0] small_mant,
    output logic [7:0]  exponent_out,
    output logic        large_sign,
    output logic        small_sign,
    output logic        eff_sub,
    output logic        guard,
    output logic        round,
    output logic        sticky
`ifdef FP_ALIGN_SPECIAL_EN
    ,
    output logic        special
`endif
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]        state;
    logic [4:0]        remaining;

    logic [MANT_W-1:0] mantA;
    logic [MANT_W-1:0] mantB;
    logic [EXP_W-1:0]  expA;
    logic [EXP_W-1:0]  expB;
    logic              swap;
    logic [4:0]        diffSat;
    logic              specialIn;

    logic [2:0]        stepAmt;
    logic [25:0]       shiftVec;
    logic [25:0]       shiftedVec;
    logic [25:0]       lostMask;
    logic              lostBit;
    logic [4:0]        remNext;

    fp_unpack uUnpack (
        .aIn     (a_in),
        .bIn     (b_in),
        .mantA   (mantA),
        .mantB   (mantB),
        .expA    (expA),
        .expB    (expB),
        .swap    (swap),
        .diffSat (diffSat)
    );

`ifdef FP_ALIGN_SPECIAL_EN
    assign specialIn = (a_in[30:23] == 8'hFF) || (b_in[30:23] == 8'hFF);
`else
    assign specialIn = 1'b0;
`endif

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // Last step of an alignment may be shorter than STEP.
    assign stepAmt    = (remaining < 5'(STEP)) ? remaining[2:0] : 3'(STEP);
    assign shiftVec   = {small_mant, guard, round};
    assign shiftedVec = shiftVec >> stepAmt;
    assign lostMask   = (26'd1 << stepAmt) - 26'd1;
    assign lostBit    = |(shiftVec & lostMask);
    assign remNext    = remaining - 5'(stepAmt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            remaining    <= '0;
            large_mant   <= '0;
            small_mant   <= '0;
            exponent_out <= '0;
            large_sign   <= 1'b0;
            small_sign   <= 1'b0;
            eff_sub      <= 1'b0;
            guard        <= 1'b0;
            round        <= 1'b0;
            sticky       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        guard   <= 1'b0;
                        round   <= 1'b0;
                        sticky  <= 1'b0;
                        eff_sub <= a_in[31] ^ b_in[31];
                        if (specialIn) begin
                            large_mant   <= mantA;
                            small_mant   <= mantB;
                            exponent_out <= expA;
                            large_sign   <= a_in[31];
                            small_sign   <= b_in[31];
                            remaining    <= '0;
                            state        <= ST_DONE;
                        end else begin
                            large_mant   <= swap ? mantB : mantA;
                            small_mant   <= swap ? mantA : mantB;
                            exponent_out <= swap ? expB : expA;
                            large_sign   <= swap ? b_in[31] : a_in[31];
                            small_sign   <= swap ? a_in[31] : b_in[31];
                            remaining    <= diffSat;
                            state        <= (diffSat == '0) ? ST_DONE : ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    small_mant <= shiftedVec[25:2];
                    guard      <= shiftedVec[1];
                    round      <= shiftedVec[0];
                    sticky     <= sticky | lostBit;
                    remaining  <= remNext;
                    if (remNext == '0) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FP_ALIGN_SPECIAL_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            special <= 1'b0;
        end else if ((state == ST_IDLE) && in_valid) begin
            special <= specialIn;
        end
    end
`endif

endmodule

// File: tb/tb_fp_align.sv
// Directed bench for fp_align, run with STEP=1 and STEP=4 instances side by side.
module tb_fp_align;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [23:0] lm;
        logic [23:0] sm;
        logic [7:0]  ex;
        logic        ls;
        logic        ss;
        logic        g;
        logic        r;
        logic        s;
        int          diff;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a_in, b_in;
    logic        in_valid, out_ready;

    logic        ir1, ov1, ls1, ss1, es1, g1, r1, s1;
    logic [23:0] lm1, sm1;
    logic [7:0]  ex1;
    logic        ir4, ov4, ls4, ss4, es4, g4, r4, s4;
    logic [23:0] lm4, sm4;
    logic [7:0]  ex4;

    int checks = 0;
    int errors = 0;
    vec_t tv[10];

    always #5 clk = ~clk;

    fp_align #(.STEP(1)) dut1 (
        .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in),
        .in_valid(in_valid), .in_ready(ir1), .out_valid(ov1), .out_ready(out_ready),
        .large_mant(lm1), .small_mant(sm1), .exponent_out(ex1),
        .large_sign(ls1), .small_sign(ss1), .eff_sub(es1),
        .guard(g1), .round(r1), .sticky(s1)
    );

    fp_align #(.STEP(4)) dut4 (
        .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in),
        .in_valid(in_valid), .in_ready(ir4), .out_valid(ov4), .out_ready(out_ready),
        .large_mant(lm4), .small_mant(sm4), .exponent_out(ex4),
        .large_sign(ls4), .small_sign(ss4), .eff_sub(es4),
        .guard(g4), .round(r4), .sticky(s4)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic checkRes(input string tag, input vec_t v);
        cmp({tag, " s1 large_mant"}, 32'(lm1), 32'(v.lm));
        cmp({tag, " s1 small_mant"}, 32'(sm1), 32'(v.sm));
        cmp({tag, " s1 exponent"},   32'(ex1), 32'(v.ex));
        cmp({tag, " s1 signs"},      32'({ls1, ss1, es1}), 32'({v.ls, v.ss, v.ls ^ v.ss}));
        cmp({tag, " s1 grs"},        32'({g1, r1, s1}), 32'({v.g, v.r, v.s}));
        cmp({tag, " s4 large_mant"}, 32'(lm4), 32'(v.lm));
        cmp({tag, " s4 small_mant"}, 32'(sm4), 32'(v.sm));
        cmp({tag, " s4 exponent"},   32'(ex4), 32'(v.ex));
        cmp({tag, " s4 signs"},      32'({ls4, ss4, es4}), 32'({v.ls, v.ss, v.ls ^ v.ss}));
        cmp({tag, " s4 grs"},        32'({g4, r4, s4}), 32'({v.g, v.r, v.s}));
    endtask

    // Accept, measure latency on both instances, optionally hold in DONE,
    // then release while in_valid is high (must not be accepted that edge).
    task automatic runVec(input string tag, input vec_t v, input int hold);
        int lat1, lat4;
        lat1 = 0;
        lat4 = 0;
        cmp({tag, " in_ready before"}, 32'({ir1, ir4}), 32'b11);
        a_in = v.a;
        b_in = v.b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (ov1 && lat1 == 0) lat1 = c;
            if (ov4 && lat4 == 0) lat4 = c;
            if (lat1 != 0 && lat4 != 0) break;
            @(posedge clk); #1;
        end
        cmp({tag, " latency s1"}, 32'(lat1), 32'(1 + v.diff));
        cmp({tag, " latency s4"}, 32'(lat4), 32'(1 + (v.diff + 3) / 4));
        checkRes(tag, v);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            cmp({tag, " hold valid/ready"}, 32'({ov1, ov4, ir1, ir4}), 32'b1100);
            checkRes({tag, " hold"}, v);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a_in      = 32'h3F800000;
        b_in      = 32'h3F800000;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        cmp({tag, " after transfer"}, 32'({ov1, ov4, ir1, ir4}), 32'b0011);
    endtask

    initial begin
        tv[0] = '{32'h3F800000, 32'h3F800000, 24'h800000, 24'h800000, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tv[1] = '{32'h40000000, 32'h3F800000, 24'h800000, 24'h400000, 8'd128, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tv[2] = '{32'h3F800000, 32'h4B800000, 24'h800000, 24'h000000, 8'd151, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24};
        tv[3] = '{32'h3F800001, 32'hCF800000, 24'h800000, 24'h000000, 8'd159, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 26};
        tv[4] = '{32'h40800000, 32'h3F800003, 24'h800000, 24'h200000, 8'd129, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2};
        tv[5] = '{32'h3F800000, 32'hBFC00000, 24'hC00000, 24'h800000, 8'd127, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tv[6] = '{32'h00000003, 32'h00800000, 24'h800000, 24'h000003, 8'd1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tv[7] = '{32'h01800000, 32'h00000005, 24'h800000, 24'h000001, 8'd3,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        tv[8] = '{32'h7F800000, 32'h3F800000, 24'h800000, 24'h000000, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 26};
        tv[9] = '{32'h3F800000, 32'hBF800000, 24'h800000, 24'h800000, 8'd127, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};

        reset     = 1'b1;
        a_in      = '0;
        b_in      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cmp("reset valid/ready", 32'({ov1, ov4, ir1, ir4}), 32'b0011);
        cmp("reset data s1", 32'({lm1, sm1} != 48'd0), 32'd0);
        cmp("reset exp/flags s1", 32'({ex1, ls1, ss1, es1, g1, r1, s1}), 32'd0);
        cmp("reset data s4", 32'({lm4, sm4} != 48'd0), 32'd0);

        for (int i = 0; i < 10; i++) begin
            runVec($sformatf("vec%0d", i), tv[i], 0);
        end

        runVec("hold", tv[4], 5);

        // Reset while both instances are still shifting a diff=20 operation.
        a_in = 32'h49800000;
        b_in = 32'h3F800000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        cmp("midshift busy", 32'({ov1, ov4, ir1, ir4}), 32'b0000);
        reset = 1'b1;
        #1;
        cmp("midreset valid/ready", 32'({ov1, ov4, ir1, ir4}), 32'b0011);
        cmp("midreset data s1", 32'({lm1, sm1} != 48'd0), 32'd0);
        cmp("midreset exp/flags s1", 32'({ex1, ls1, ss1, es1, g1, r1, s1}), 32'd0);
        cmp("midreset data s4", 32'({lm4, sm4} != 48'd0), 32'd0);
        cmp("midreset exp/flags s4", 32'({ex4, ls4, ss4, es4, g4, r4, s4}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        cmp("postreset ready", 32'({ov1, ov4, ir1, ir4}), 32'b0011);
        runVec("postreset", tv[4], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
